// File: rtl/apb_pkg.sv
// Shared types and default widths for the zero-wait-state APB completer.
// The FSM encoding is also visible on the debug state output of the top.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_MEM_DEPTH  = 64;

endpackage

// File: rtl/apb_regfile.sv
// Word-addressed register array with asynchronous clear.
// Provides one synchronous write port and one combinational read port.
module apb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_WIDTH  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [IDX_WIDTH-1:0]  wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [IDX_WIDTH-1:0]  rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/apb_modport_slave.sv
// Zero-wait-state APB completer in front of a register file.
// Out-of-range indices and ENABLE without a preceding SETUP return PSLVERR.
module apb_modport_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic [1:0]            fsm_state
);

    localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Handshake: a transfer is a SETUP cycle (PSEL & !PENABLE) followed by one
    // ACCESS cycle (PSEL & PENABLE); PREADY is high in every ACCESS cycle, so
    // each transfer completes in exactly two cycles with no wait states.

    apb_state_e            state_q;
    logic                  setup_cyc;
    logic                  access_cyc;
    logic                  addr_err;
    logic                  proto_err;
    logic                  wr_en;
    logic                  rd_load;
    logic [DATA_WIDTH-1:0] rd_data;

    assign setup_cyc  = PSEL & ~PENABLE;
    assign access_cyc = PSEL & PENABLE;
    assign addr_err   = (PADDR >= ADDR_WIDTH'(MEM_DEPTH));
    // The state register lags the bus by one cycle, so a legal ENABLE sees SETUP.
    assign proto_err  = access_cyc & (state_q != SETUP);

    assign PREADY    = access_cyc;
    assign PSLVERR   = PREADY & (addr_err | proto_err);
    assign fsm_state = state_q;

    assign wr_en   = access_cyc & PWRITE & ~addr_err & ~proto_err;
    assign rd_load = setup_cyc & ~PWRITE;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    state_q <= setup_cyc ? SETUP : IDLE;
                SETUP:   state_q <= ACCESS;
                ACCESS:  state_q <= setup_cyc ? SETUP : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PRDATA <= '0;
        end else if (rd_load) begin
            PRDATA <= addr_err ? '0 : rd_data;
        end
    end

    apb_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_regfile (
        .clk     (PCLK),
        .rst     (PRESET),
        .wr_en   (wr_en),
        .wr_idx  (PADDR[IDX_WIDTH-1:0]),
        .wr_data (PWDATA),
        .rd_idx  (PADDR[IDX_WIDTH-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_apb_modport_slave.sv
// Directed bench for the APB completer: reset, reads/writes, errors,
// back-to-back transfers and reset during a write ACCESS.
module tb_apb_modport_slave;

    logic        pclk;
    logic        preset;
    logic        psel;
    logic        penable;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  fsm_state;

    int tests_run;
    int tests_failed;

    logic        rdy;
    logic        err;
    logic [31:0] data;
    logic [1:0]  st;

    apb_modport_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (64)
    ) dut (
        .PCLK      (pclk),
        .PRESET    (preset),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PADDR     (paddr),
        .PWRITE    (pwrite),
        .PWDATA    (pwdata),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // driver tasks: each leaves the bus in ACCESS so transfers can chain
    task automatic apb_write(input logic [7:0] a, input logic [31:0] d,
                             output logic r, output logic e);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b1; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        r = pready; e = pslverr;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d,
                            output logic r, output logic e, output logic [1:0] s);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = 1'b0; pwdata = 32'h0;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        d = prdata; r = pready; e = pslverr; s = fsm_state;
    endtask

    task automatic bus_idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        preset = 1'b1;
        psel = 1'b0; penable = 1'b0; paddr = 8'h00; pwrite = 1'b0; pwdata = 32'h0;

        // reset held three cycles
        repeat (3) @(posedge pclk);
        #1 preset = 1'b0;
        @(negedge pclk);
        check("rst_prdata", prdata, 32'h0);
        check("rst_pready", {31'b0, pready}, 32'h0);
        check("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check("rst_state", {30'b0, fsm_state}, 32'd0);

        apb_read(8'h05, data, rdy, err, st);
        check("rst_rd5_data", data, 32'h0);
        check("rst_rd5_err", {31'b0, err}, 32'h0);
        bus_idle();

        // basic write then read
        apb_write(8'h00, 32'hA5A5_5A5A, rdy, err);
        bus_idle();
        apb_write(8'h05, 32'hDEAD_BEEF, rdy, err);
        check("wr5_ready", {31'b0, rdy}, 32'h1);
        check("wr5_err", {31'b0, err}, 32'h0);
        bus_idle();
        apb_read(8'h05, data, rdy, err, st);
        check("rd5_data", data, 32'hDEAD_BEEF);
        check("rd5_ready", {31'b0, rdy}, 32'h1);
        check("rd5_err", {31'b0, err}, 32'h0);
        bus_idle();

        // out-of-range index
        apb_write(8'h40, 32'h1234_5678, rdy, err);
        check("wr40_ready", {31'b0, rdy}, 32'h1);
        check("wr40_err", {31'b0, err}, 32'h1);
        bus_idle();
        apb_read(8'h40, data, rdy, err, st);
        check("rd40_data", data, 32'h0);
        check("rd40_err", {31'b0, err}, 32'h1);
        bus_idle();
        apb_read(8'h00, data, rdy, err, st);
        check("rd0_unchanged", data, 32'hA5A5_5A5A);
        apb_read(8'hFF, data, rdy, err, st);
        check("rdff_err", {31'b0, err}, 32'h1);
        bus_idle();

        // back-to-back write then read, no idle between
        apb_write(8'h01, 32'h0000_0011, rdy, err);
        check("b2b_wr_err", {31'b0, err}, 32'h0);
        apb_read(8'h01, data, rdy, err, st);
        check("b2b_rd_data", data, 32'h0000_0011);
        check("b2b_rd_err", {31'b0, err}, 32'h0);
        check("b2b_state", {30'b0, st}, 32'd1);
        apb_write(8'h01, 32'h0000_0022, rdy, err);
        check("wr_keeps_prdata", prdata, 32'h0000_0011);
        apb_read(8'h3F, data, rdy, err, st);
        check("rd3f_top_valid", data, 32'h0);
        check("rd3f_err", {31'b0, err}, 32'h0);
        apb_read(8'h01, data, rdy, err, st);
        check("rd1_new", data, 32'h0000_0022);
        bus_idle();

        // ENABLE without SETUP from IDLE
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h03; pwdata = 32'hCAFE_F00D;
        @(negedge pclk);
        check("proto_ready", {31'b0, pready}, 32'h1);
        check("proto_err", {31'b0, pslverr}, 32'h1);
        bus_idle();
        apb_read(8'h03, data, rdy, err, st);
        check("proto_mem", data, 32'h0);
        bus_idle();

        // reset during the ACCESS of a write
        apb_write(8'h02, 32'h0BAD_0BAD, rdy, err);
        preset = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(negedge pclk);
        check("rst_mid_state", {30'b0, fsm_state}, 32'd0);
        check("rst_mid_prdata", prdata, 32'h0);
        apb_read(8'h02, data, rdy, err, st);
        check("rst_mid_mem2", data, 32'h0);
        bus_idle();
        apb_read(8'h05, data, rdy, err, st);
        check("rst_clears_mem5", data, 32'h0);
        bus_idle();

        repeat (2) @(posedge pclk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
